// File: rtl/pengo_pkg.sv
// pengo_pkg: shared region map, region one-hot encoding and loader FSM states.
// No ports; imported by the decoder, the loader top and test code.
package pengo_pkg;
    typedef enum logic [3:0] {
        REG_NONE = 4'b0000,
        REG_PROG = 4'b0001,
        REG_GFX  = 4'b0010,
        REG_CLUT = 4'b0100,
        REG_SND  = 4'b1000
    } region_t;

    typedef enum logic [1:0] {ST_BOOT, ST_IDLE, ST_LOAD, ST_HOLD} state_t;

    localparam logic [15:0] GFX_BASE  = 16'h8000;
    localparam logic [15:0] CLUT_BASE = 16'hC000;
    localparam logic [15:0] SND_BASE  = 16'hC120;
    localparam logic [15:0] END_ADDR  = 16'hC220;

    // Indexed by one-hot bit position: PROG, GFX, CLUT, SND.
    localparam logic [15:0] REGION_SIZE [4] = '{16'h8000, 16'h4000, 16'h0120, 16'h0100};
endpackage

// File: rtl/pengo_region_decode.sv
// pengo_region_decode: combinational byte address -> one-hot ROM region and in-range flag.
// Ports: addr (25-bit ioctl byte address) in; region (one-hot {SND,CLUT,GFX,PROG}), in_range out.
module pengo_region_decode
    import pengo_pkg::*;
(
    input  logic [24:0] addr,
    output region_t     region,
    output logic        in_range
);
    logic [15:0] a;
    assign a = addr[15:0];
    always_comb begin
        region = addr[24:16] != '0 ? REG_NONE :
                 a < GFX_BASE      ? REG_PROG :
                 a < CLUT_BASE     ? REG_GFX  :
                 a < SND_BASE      ? REG_CLUT :
                 a < END_ADDR      ? REG_SND  : REG_NONE;
        in_range = region != REG_NONE;
    end
endmodule

// File: rtl/pengo_rom_loader.sv
// pengo_rom_loader: routes the HPS ROM download into Pengo ROM regions and gates core reset.
// Ports: clk_sys, reset_n (async, active low); ioctl_download/wr/addr/dout from hps_io;
// ext_reset (menu/button); dn_addr/dn_data/dn_wr/dn_region registered core writes;
// core_reset to the core; load_done/load_err sticky status; checksum of accepted bytes.
module pengo_rom_loader
    import pengo_pkg::*;
#(
    parameter int HOLD_CYCLES = 1024,
    parameter int ADDR_W      = 16
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic              ext_reset,
    output logic [ADDR_W-1:0] dn_addr,
    output logic [7:0]        dn_data,
    output logic              dn_wr,
    output logic [3:0]        dn_region,
    output logic              core_reset,
    output logic              load_done,
    output logic              load_err,
    output logic [7:0]        checksum
);
    localparam int CW = $clog2(HOLD_CYCLES + 1);

    state_t        state, state_nx;
    region_t       region;
    logic          in_range, dl_q, rise, fall, start, wr_ok, bad_wr, hold_end, complete;
    logic [CW-1:0] hold_cnt;
    logic [15:0]   cnt [4];

    pengo_region_decode u_decode (
        .addr     (ioctl_addr),
        .region   (region),
        .in_range (in_range)
    );

    assign rise     = ioctl_download & ~dl_q;
    assign fall     = ~ioctl_download & dl_q;
    assign start    = rise & (state == ST_IDLE || state == ST_HOLD);
    assign wr_ok    = state == ST_LOAD && ioctl_wr && in_range;
    assign bad_wr   = state == ST_LOAD && ioctl_wr && !in_range;
    assign hold_end = state == ST_HOLD && !rise && hold_cnt == '0;
    assign complete = cnt[0] == REGION_SIZE[0] && cnt[1] == REGION_SIZE[1] &&
                      cnt[2] == REGION_SIZE[2] && cnt[3] == REGION_SIZE[3];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= ST_BOOT;
        else          state <= state_nx;
    end

    // Core reset is combinational so ext_reset reaches the core with no added latency in IDLE.
    always_comb begin
        state_nx   = state;
        core_reset = 1'b1;
        case (state)
            ST_BOOT: state_nx = ioctl_download ? ST_BOOT : ST_IDLE;
            ST_IDLE: begin
                core_reset = load_done ? ext_reset : 1'b1;
                state_nx   = rise ? ST_LOAD : ST_IDLE;
            end
            ST_LOAD: state_nx = fall ? ST_HOLD : ST_LOAD;
            default: state_nx = rise ? ST_LOAD : hold_cnt == '0 ? ST_IDLE : ST_HOLD;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dl_q      <= 1'b0;
            dn_addr   <= '0;
            dn_data   <= '0;
            dn_wr     <= 1'b0;
            dn_region <= '0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            checksum  <= '0;
            hold_cnt  <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            dl_q      <= ioctl_download;
            dn_wr     <= wr_ok;
            dn_region <= wr_ok ? region : REG_NONE;
            if (wr_ok) begin
                dn_addr <= ioctl_addr[ADDR_W-1:0];
                dn_data <= ioctl_dout;
            end
            hold_cnt <= state == ST_LOAD && fall ? CW'(HOLD_CYCLES - 1) :
                        state == ST_HOLD          ? hold_cnt - CW'(1) : hold_cnt;
            if (start) begin
                load_done <= 1'b0;
                load_err  <= 1'b0;
                checksum  <= '0;
                for (int i = 0; i < 4; i++) cnt[i] <= '0;
            end else begin
                if (wr_ok) checksum <= checksum + ioctl_dout;
                for (int i = 0; i < 4; i++)
                    if (wr_ok && region[i] && cnt[i] != 16'hFFFF) cnt[i] <= cnt[i] + 16'd1;
                if (bad_wr || (hold_end && !complete)) load_err <= 1'b1;
                if (hold_end && complete) load_done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pengo_rom_loader.sv
// tb_pengo_rom_loader: directed table plus hand sequences for pengo_rom_loader.
module tb_pengo_rom_loader;
    localparam int HOLD = 16;

    logic        clk_sys = 1'b0, reset_n = 1'b0;
    logic        ioctl_download = 1'b0, ioctl_wr = 1'b0, ext_reset = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data, checksum;
    logic        dn_wr, core_reset, load_done, load_err;
    logic [3:0]  dn_region;

    int checks = 0, failures = 0, pulses = 0;

    pengo_rom_loader #(.HOLD_CYCLES(HOLD), .ADDR_W(16)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ext_reset(ext_reset), .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr),
        .dn_region(dn_region), .core_reset(core_reset), .load_done(load_done),
        .load_err(load_err), .checksum(checksum)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) if (dn_wr) pulses <= pulses + 1;

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
        logic        exp_wr;
        logic [3:0]  exp_region;
    } vec_t;
    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick(1);
        ioctl_wr   = 1'b0;
    endtask

    task automatic start_dl();
        ioctl_download = 1'b1;
        tick(1);
    endtask

    task automatic end_dl();
        ioctl_download = 1'b0;
        tick(HOLD + 2);
    endtask

    initial begin
        int base, n;
        logic [7:0] sum;
        vecs[0]  = '{25'h0000000, 8'h10, 1'b1, 4'b0001};
        vecs[1]  = '{25'h0007FFF, 8'h20, 1'b1, 4'b0001};
        vecs[2]  = '{25'h0008000, 8'h30, 1'b1, 4'b0010};
        vecs[3]  = '{25'h000BFFF, 8'h40, 1'b1, 4'b0010};
        vecs[4]  = '{25'h000C000, 8'h50, 1'b1, 4'b0100};
        vecs[5]  = '{25'h000C11F, 8'h60, 1'b1, 4'b0100};
        vecs[6]  = '{25'h000C120, 8'h70, 1'b1, 4'b1000};
        vecs[7]  = '{25'h000C21F, 8'h80, 1'b1, 4'b1000};
        vecs[8]  = '{25'h000C220, 8'h99, 1'b0, 4'b0000};
        vecs[9]  = '{25'h000FFFF, 8'h99, 1'b0, 4'b0000};
        vecs[10] = '{25'h0010000, 8'h99, 1'b0, 4'b0000};
        vecs[11] = '{25'h001C000, 8'h99, 1'b0, 4'b0000};

        #1;
        check("rst_dn_wr", dn_wr, 0);
        check("rst_dn_region", dn_region, 0);
        check("rst_dn_addr", dn_addr, 0);
        check("rst_core_reset", core_reset, 1);
        check("rst_load_done", load_done, 0);
        check("rst_load_err", load_err, 0);
        check("rst_checksum", checksum, 0);
        tick(2);
        reset_n = 1'b1;
        tick(3);

        ext_reset = 1'b1;
        #1 check("ext_before_load_hi", core_reset, 1);
        ext_reset = 1'b0;
        #1 check("ext_before_load_lo", core_reset, 1);

        wr_byte(25'h10, 8'h55);
        check("wr_outside_load", dn_wr, 0);

        start_dl();
        sum = 8'h00;
        for (int i = 0; i < 12; i++) begin
            wr_byte(vecs[i].addr, vecs[i].data);
            check($sformatf("vec%0d_wr", i), dn_wr, vecs[i].exp_wr);
            check($sformatf("vec%0d_region", i), dn_region, vecs[i].exp_region);
            if (vecs[i].exp_wr) begin
                check($sformatf("vec%0d_addr", i), dn_addr, vecs[i].addr[15:0]);
                check($sformatf("vec%0d_data", i), dn_data, vecs[i].data);
                sum = sum + vecs[i].data;
            end
        end
        check("table_checksum", checksum, sum);
        end_dl();
        check("table_err", load_err, 1);
        check("table_done", load_done, 0);
        check("table_core_reset", core_reset, 1);

        start_dl();
        check("restart_clears_err", load_err, 0);
        base = pulses;
        wr_byte(25'h7FFE, 8'h01);
        check("b2b0_region", dn_region, 4'b0001);
        wr_byte(25'h7FFF, 8'h02);
        check("b2b1_region", dn_region, 4'b0001);
        wr_byte(25'h8000, 8'h03);
        check("b2b2_region", dn_region, 4'b0010);
        wr_byte(25'h8001, 8'h04);
        check("b2b3_region", dn_region, 4'b0010);
        check("b2b3_addr", dn_addr, 16'h8001);
        tick(1);
        check("b2b_pulses", pulses - base, 4);
        check("b2b_idle_wr", dn_wr, 0);
        end_dl();
        check("b2b_err", load_err, 1);

        start_dl();
        for (int a = 'hC120; a <= 'hC21E; a++) wr_byte(25'(a), 8'h02);
        check("short_checksum", checksum, 8'hFE);
        end_dl();
        tick(5);
        check("short_err", load_err, 1);
        check("short_done", load_done, 0);
        check("short_core_reset", core_reset, 1);

        start_dl();
        for (int a = 0; a < 'h4000; a++) wr_byte(25'(a), 8'h01);
        wr_byte(25'h4000, 8'h01);
        check("pre_rst_wr", dn_wr, 1);
        reset_n = 1'b0;
        #1;
        check("async_dn_wr", dn_wr, 0);
        check("async_dn_addr", dn_addr, 0);
        check("async_dn_region", dn_region, 0);
        check("async_checksum", checksum, 0);
        check("async_core_reset", core_reset, 1);
        @(posedge clk_sys);
        #1 reset_n = 1'b1;
        base = pulses;
        wr_byte(25'h4001, 8'h01);
        wr_byte(25'h4002, 8'h01);
        tick(1);
        check("stale_dl_no_wr", pulses - base, 0);
        ioctl_download = 1'b0;
        tick(2);
        check("boot_idle_core_reset", core_reset, 1);

        start_dl();
        base = pulses;
        for (int a = 0; a < 'hC220; a++) wr_byte(25'(a), 8'h01);
        tick(1);
        check("full_pulses", pulses - base, 'hC220);
        check("full_checksum", checksum, 8'h20);
        ioctl_download = 1'b0;
        n = 0;
        while (core_reset && n < 2 * HOLD + 10) begin
            tick(1);
            n++;
        end
        check("full_release_cycles", n, HOLD + 1);
        check("full_done", load_done, 1);
        check("full_err", load_err, 0);

        ext_reset = 1'b1;
        #1 check("ext_after_done_hi", core_reset, 1);
        ext_reset = 1'b0;
        #1 check("ext_after_done_lo", core_reset, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pengo_rom_loader.md
# pengo_rom_loader

Sequences the HPS ROM download stream into the Pengo core's ROM regions and gates core reset around it. It sits between `hps_io` (`ioctl_*`) and the `pengo` core (`dn_addr`/`dn_data`/`dn_wr`, `reset`). It decodes each byte into a region write strobe and counts bytes per region. It holds the core in reset during the load and for a settle period afterwards, then reports completion or a short-load error.

## Interface
Parameters:
- `HOLD_CYCLES`, default 1024: clk_sys cycles core reset stays asserted after download ends.
- `ADDR_W`, default 16: width of `dn_addr`.

Ports:
- `clk_sys`, in, 1: system clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `ioctl_download`, in, 1: download window from `hps_io`.
- `ioctl_wr`, in, 1: one-cycle byte strobe.
- `ioctl_addr`, in, 25: byte address.
- `ioctl_dout`, in, 8: byte data.
- `ext_reset`, in, 1: OR of menu reset and user button.
- `dn_addr`, out, ADDR_W: registered write address to the core.
- `dn_data`, out, 8: registered write data.
- `dn_wr`, out, 1: registered write strobe.
- `dn_region`, out, 4: one-hot region select {SND, CLUT, GFX, PROG}, valid with `dn_wr`.
- `core_reset`, out, 1: active-high reset to the core.
- `load_done`, out, 1: sticky; set once a complete image has loaded.
- `load_err`, out, 1: sticky; set when the last download was short or out of range.
- `checksum`, out, 8: modulo-256 sum of all accepted bytes of the last download.

## Operation
- Region map, fixed:
  - PROG: 0x0000–0x7FFF (32768 B).
  - GFX: 0x8000–0xBFFF (16384 B).
  - CLUT: 0xC000–0xC11F (288 B).
  - SND: 0xC120–0xC21F (256 B).
  - Any address ≥ 0xC220, or with `ioctl_addr[24:16] != 0`, is out of range.
- FSM states: BOOT, IDLE, LOAD, HOLD.
  - BOOT (after reset): `core_reset`=1. Go to IDLE when `ioctl_download`=0. This keeps the core reset at power-up until the first image arrives; `load_done`=0.
  - IDLE: `core_reset` = `ext_reset` & `load_done`, or 1 if `load_done`=0. On the rising edge of `ioctl_download`: go to LOAD, clear the region counters, `checksum`, `load_done` and `load_err`.
  - LOAD: `core_reset`=1. Each `ioctl_wr` with an in-range address produces one `dn_wr` pulse one cycle later, with `dn_addr=ioctl_addr[ADDR_W-1:0]`, `dn_data`, `dn_region` one-hot, the region counter incremented and `checksum` += data.
    - Out-of-range write: no `dn_wr`, and `load_err` is set.
    - `ioctl_wr` outside LOAD is ignored.
    - On the falling edge of `ioctl_download`: go to HOLD and load the hold counter with `HOLD_CYCLES-1`.
  - HOLD: `core_reset`=1, counter decrements each cycle. At 0, evaluate the image:
    - All four region counters equal their region sizes: set `load_done`.
    - Otherwise: set `load_err`.
    - Go to IDLE.
  - A new rising edge of `ioctl_download` during HOLD aborts HOLD and re-enters LOAD with counters cleared.
- Region counters are 16-bit and saturate at 0xFFFF; duplicate addresses count each time. Over-count also fails the completion check.
- `dn_wr` is never asserted outside LOAD, or in the cycle after the LOAD→HOLD transition unless it carries a write captured in LOAD.

## Timing
- `ioctl_wr` at cycle N → `dn_wr`, `dn_addr`, `dn_data`, `dn_region` at N+1, each for exactly 1 cycle. Back-to-back strobes on consecutive cycles are supported at full rate.
- The `ioctl_download` edge is detected from a 1-cycle registered copy, so the state change occurs at N+1 after the edge.
- `core_reset` release: `HOLD_CYCLES`+1 cycles after the `ioctl_download` falling edge is registered.
- `load_done`/`load_err` update in the same cycle as HOLD→IDLE.
- Reset values, all outputs: `dn_*`=0, `dn_region`=0, `core_reset`=1, `load_done`=0, `load_err`=0, `checksum`=0.
- `reset_n` asserted mid-LOAD: everything returns to reset values immediately (asynchronous). FSM restarts in BOOT. A download still in progress is treated as not started until its next rising edge.

## Structure
- Package `pengo_pkg`: region base/size constants, the region one-hot enum, and the FSM state typedef.
- One sub-module, `pengo_region_decode`, is natural: combinational address → {one-hot, in_range}, reused by test code.

## Test plan
- Full image: 0xC220 sequential bytes of value 0x01 → 0xC220 `dn_wr` pulses; `checksum`=0x20; `load_done`=1 after HOLD; `core_reset` falls exactly `HOLD_CYCLES`+1 cycles after the download ends.
- Short image: stop at 0xC21E → `load_err`=1, `load_done`=0, `core_reset` stays 1.
- Out-of-range write at 0x1C000 mid-load → no `dn_wr` for that byte; `load_err`=1 at the end.
- Back-to-back `ioctl_wr` on 4 consecutive cycles crossing 0x7FFE–0x8001 → 4 pulses with `dn_region` 0001, 0001, 0010, 0010.
- `reset_n` pulsed low at byte 0x4000 → outputs return to reset values asynchronously; a restarted full download completes with `load_done`=1.
- `ext_reset` after `load_done` → `core_reset` follows it with 0 cycles of latency in IDLE; `ext_reset` before any download leaves `core_reset`=1.
